rs232_txd_param: RTL and testbench

Parametrised RS-232 asynchronous transmitter. It is the successor to the team's fixed 8N1 transmitter. It serialises one DataIn word per request into a start bit, DATA_BITS data bits (LSB first), an optional parity bit and 1 or 2 stop bits. It runs entirely in the Clock16x domain, with each bit held for TICKS_PER_BIT clocks, and exposes a Busy/Done handshake to the upstream controller.

---
 rtl/rs232_txd_param.sv | 151 +++++++++++++++
 tb/tb_rs232_txd_param.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rs232_txd_param.sv
// rs232_txd_param -- parametrised RS-232 asynchronous transmitter.
//
// Sends one DataIn word per accepted request. The frame is a start bit,
// DATA_BITS data bits (LSB first), an optional parity bit, and STOP_BITS
// stop bits. Each bit is held for TICKS_PER_BIT Clock16x cycles.
//
// Ports:
//   Clock16x  in   oversampled baud clock; all logic runs on its rising edge
//   Reset     in   synchronous, active-high; aborts any frame in flight
//   Send      in   level-sensitive request; accepted when Busy = 0
//   DataIn    in   word to send, captured at the acceptance edge
//   Txd       out  serial line, idle high, driven from a flop
//   Busy      out  high while a frame is on the line
//   Done      out  one-cycle pulse in the cycle after the last stop bit
module rs232_txd_param #(
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic                 Clock16x,
  input  logic                 Reset,
  input  logic                 Send,
  input  logic [DATA_BITS-1:0] DataIn,
  output logic                 Txd,
  output logic                 Busy,
  output logic                 Done
);

  localparam int             TW        = $clog2(TICKS_PER_BIT);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic           HAS_PAR   = (PARITY_MODE != 0);
  localparam logic           PAR_ODD   = (PARITY_MODE == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, stateN;
  logic [TW-1:0]        tickCnt, tickN;
  logic [3:0]           bitCnt, bitN;
  logic [DATA_BITS-1:0] shiftReg, shiftN;
  logic                 parBit, parN;
  logic                 txdN, busyN, doneN;
  logic                 tickEnd;

  assign tickEnd = (tickCnt == TICK_LAST);

  always_ff @(posedge Clock16x) begin
    if (Reset) begin
      state    <= IDLE;
      tickCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      parBit   <= 1'b0;
      Txd      <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= stateN;
      tickCnt  <= tickN;
      bitCnt   <= bitN;
      shiftReg <= shiftN;
      parBit   <= parN;
      Txd      <= txdN;
      Busy     <= busyN;
      Done     <= doneN;
    end
  end

  always_comb begin
    stateN = state;
    tickN  = tickCnt;
    bitN   = bitCnt;
    shiftN = shiftReg;
    parN   = parBit;
    txdN   = Txd;
    busyN  = Busy;
    doneN  = 1'b0;

    // Tick counter free-runs inside a frame and wraps at the end of every bit.
    if (state != IDLE)
      tickN = tickEnd ? '0 : tickCnt + 1'b1;

    unique case (state)
      IDLE: begin
        if (Send && !Busy) begin
          stateN = START;
          shiftN = DataIn;
          // Parity is fixed at capture so later DataIn changes cannot leak in.
          parN   = (^DataIn) ^ PAR_ODD;
          tickN  = '0;
          bitN   = '0;
          txdN   = 1'b0;
          busyN  = 1'b1;
        end
      end
      START: begin
        if (tickEnd) begin
          stateN = DATA;
          txdN   = shiftReg[0];
          shiftN = shiftReg >> 1;
          bitN   = '0;
        end
      end
      DATA: begin
        if (tickEnd) begin
          if (bitCnt == DATA_LAST) begin
            bitN = '0;
            if (HAS_PAR) begin
              stateN = PARITY;
              txdN   = parBit;
            end else begin
              stateN = STOP;
              txdN   = 1'b1;
            end
          end else begin
            bitN   = bitCnt + 4'd1;
            txdN   = shiftReg[0];
            shiftN = shiftReg >> 1;
          end
        end
      end
      PARITY: begin
        if (tickEnd) begin
          stateN = STOP;
          txdN   = 1'b1;
          bitN   = '0;
        end
      end
      STOP: begin
        if (tickEnd) begin
          if (bitCnt == STOP_LAST) begin
            stateN = IDLE;
            busyN  = 1'b0;
            doneN  = 1'b1;
            txdN   = 1'b1;
          end else begin
            bitN = bitCnt + 4'd1;
          end
        end
      end
      default: begin
        stateN = IDLE;
        txdN   = 1'b1;
        busyN  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rs232_txd_param.sv
module tb_rs232_txd_param;

  localparam int T = 16;
  // Three transmitters: 8N1 defaults, 8E1, 7O2.
  localparam int DB [3] = '{8, 8, 7};
  localparam int PM [3] = '{0, 2, 1};
  localparam int SB [3] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst  [3];
  logic       send [3];
  logic [8:0] din  [3];
  logic       txd  [3];
  logic       busy [3];
  logic       done [3];

  int nAsserts = 0;
  int nFails   = 0;

  always #5 clk = ~clk;

  rs232_txd_param u0 (
    .Clock16x(clk), .Reset(rst[0]), .Send(send[0]), .DataIn(din[0][7:0]),
    .Txd(txd[0]), .Busy(busy[0]), .Done(done[0]));

  rs232_txd_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .TICKS_PER_BIT(16)) u1 (
    .Clock16x(clk), .Reset(rst[1]), .Send(send[1]), .DataIn(din[1][7:0]),
    .Txd(txd[1]), .Busy(busy[1]), .Done(done[1]));

  rs232_txd_param #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .TICKS_PER_BIT(16)) u2 (
    .Clock16x(clk), .Reset(rst[2]), .Send(send[2]), .DataIn(din[2][6:0]),
    .Txd(txd[2]), .Busy(busy[2]), .Done(done[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int frameLen(input int c);
    return T * (1 + DB[c] + (PM[c] != 0 ? 1 : 0) + SB[c]);
  endfunction

  // Value of the idx-th serial bit of a frame carrying d.
  function automatic int expBit(input int c, input int d, input int idx);
    int ones;
    if (idx == 0) return 0;
    if (idx <= DB[c]) return (d >> (idx - 1)) & 1;
    if (PM[c] != 0 && idx == DB[c] + 1) begin
      ones = 0;
      for (int i = 0; i < DB[c]; i++) ones += (d >> i) & 1;
      return (PM[c] == 2) ? (ones % 2) : (1 - ones % 2);
    end
    return 1;
  endfunction

  task automatic start(input int c, input int d);
    @(negedge clk);
    din[c]  = 9'(d);
    send[c] = 1'b1;
  endtask

  task automatic idleChk(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("c%0d idle%0d txd", c, k), int'(txd[c]), 1);
      chk($sformatf("c%0d idle%0d busy", c, k), int'(busy[c]), 0);
      chk($sformatf("c%0d idle%0d done", c, k), int'(done[c]), 0);
    end
  endtask

  // Checks one frame whose acceptance edge has just passed or is the next
  // posedge. injAt > 0 re-asserts Send with other data mid-frame; abortAt > 0
  // resets the DUT at that cycle (with Send also high) and checks the abort.
  task automatic frame(input int c, input int d, input bit hold,
                       input int injAt, input int abortAt);
    int f;
    f = frameLen(c);
    for (int k = 1; k <= f; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) send[c] = 1'b0;
      chk($sformatf("c%0d d%0h k%0d txd", c, d, k), int'(txd[c]), expBit(c, d, (k - 1) / T));
      chk($sformatf("c%0d d%0h k%0d busy", c, d, k), int'(busy[c]), 1);
      chk($sformatf("c%0d d%0h k%0d done", c, d, k), int'(done[c]), 0);
      if (injAt > 0 && k == injAt) begin
        send[c] = 1'b1;
        din[c]  = 9'h03C;
      end
      if (injAt > 0 && k == injAt + 1) send[c] = 1'b0;
      if (abortAt > 0 && k == abortAt) begin
        rst[c]  = 1'b1;
        send[c] = 1'b1;
        din[c]  = 9'h0FF;
        @(negedge clk);
        rst[c]  = 1'b0;
        send[c] = 1'b0;
        chk($sformatf("c%0d abort txd", c), int'(txd[c]), 1);
        chk($sformatf("c%0d abort busy", c), int'(busy[c]), 0);
        chk($sformatf("c%0d abort done", c), int'(done[c]), 0);
        idleChk(c, 20);
        return;
      end
    end
    @(negedge clk);
    chk($sformatf("c%0d d%0h end txd", c, d), int'(txd[c]), 1);
    chk($sformatf("c%0d d%0h end busy", c, d), int'(busy[c]), 0);
    chk($sformatf("c%0d d%0h end done", c, d), int'(done[c]), 1);
  endtask

  initial begin
    int d;
    for (int c = 0; c < 3; c++) begin
      rst[c] = 1'b1; send[c] = 1'b0; din[c] = '0;
    end
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("c%0d reset txd", c), int'(txd[c]), 1);
      chk($sformatf("c%0d reset busy", c), int'(busy[c]), 0);
      chk($sformatf("c%0d reset done", c), int'(done[c]), 0);
      rst[c] = 1'b0;
    end

    // 8N1, 0xA5, single-cycle Send pulse.
    start(0, 'hA5); frame(0, 'hA5, 1'b0, 0, 0);
    idleChk(0, 5);

    // Even parity: 0x03 -> 0, 0x07 -> 1.
    start(1, 'h03); frame(1, 'h03, 1'b0, 0, 0);
    start(1, 'h07); frame(1, 'h07, 1'b0, 0, 0);

    // 7O2 with all ones: odd parity bit is 0.
    start(2, 'h7F); frame(2, 'h7F, 1'b0, 0, 0);
    idleChk(2, 5);

    // Send during a frame is ignored; only one Done, then idle.
    start(0, 'hA5); frame(0, 'hA5, 1'b0, 50, 0);
    idleChk(0, 20);

    // Reset mid-frame (with Send high), then a fresh frame.
    start(0, 'hA5); frame(0, 'hA5, 1'b0, 0, 70);
    start(0, 'h5A); frame(0, 'h5A, 1'b0, 0, 0);
    idleChk(0, 3);

    // Send held high: three back-to-back frames with one idle cycle between.
    start(0, 'h55);
    frame(0, 'h55, 1'b1, 0, 0);
    frame(0, 'h55, 1'b1, 0, 0);
    frame(0, 'h55, 1'b0, 0, 0);
    idleChk(0, 20);

    // Random data on every configuration.
    for (int c = 0; c < 3; c++) begin
      for (int n = 0; n < 4; n++) begin
        d = int'($urandom & ((1 << DB[c]) - 1));
        start(c, d); frame(c, d, 1'b0, 0, 0);
        idleChk(c, int'($urandom_range(0, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
